aluv_op_sequencer: RTL and testbench
====================================

// Module: aluv_op_sequencer
// PURPOSE
//  Issue controller for the 6-lane vector ALU in the Execute stage.
//  - Accepts one vector op per valid/ready handshake and holds selector/operands stable for the op's latency.
//  - Captures the ALU result and returns it on a valid/ready response port.
//  - Gives MUL/DIV a multi-cycle timing budget; ALU is instantiated by the parent, combinational.
// PARAMETERS
//  DATA_WIDTH     8  bits per lane
//  LANES          6  lanes per vector
//  SELECTOR_SIZE  3  ALU selector width
//  FAST_CYCLES    1  latency of ADD/SUB/PASS/reserved ops (>=1)
//  MUL_CYCLES     2  latency of MUL (>=1)
//  DIV_CYCLES     4  latency of DIV (>=1)
// PORTS
//  clk        in   1                  rising-edge clock
//  reset      in   1                  synchronous, active-high
//  req_valid  in   1                  request present
//  req_ready  out  1                  sequencer can accept
//  req_op     in   SELECTOR_SIZE      000 ADD,001 SUB,010 MUL,011 DIV,100 PASS1,101 PASS2,11x reserved
//  req_a      in   LANES*DATA_WIDTH   operand1, lane0 at LSBs
//  req_b      in   LANES*DATA_WIDTH   operand2, lane0 at LSBs
//  alu_sel    out  SELECTOR_SIZE      to ALU selector
//  alu_op1    out  LANES*DATA_WIDTH   to ALU operand1
//  alu_op2    out  LANES*DATA_WIDTH   to ALU operand2
//  alu_out    in   LANES*DATA_WIDTH   from ALU result
//  rsp_valid  out  1                  result available
//  rsp_ready  in   1                  consumer takes result
//  rsp_data   out  LANES*DATA_WIDTH   captured result
//  rsp_dz     out  LANES              per-lane divide-by-zero (DIV only, else 0)
//  busy       out  1                  state != IDLE
// BEHAVIOUR
//  FSM IDLE -> EXEC -> DONE -> IDLE.
//  - req_ready=1 only in IDLE.
//  - Accept on req_valid&req_ready: latch op/a/b, load cnt=LAT(op)-1, go EXEC.
//  - alu_sel/alu_op1/alu_op2 driven from latched regs only; stable for the whole EXEC.
//  - EXEC with cnt!=0: cnt--.
//  - EXEC with cnt==0: rsp_data<=alu_out; rsp_dz[i]<=(op==DIV)&&(b lane i==0); go DONE.
//  - DONE: rsp_valid=1, rsp_data/rsp_dz held; on rsp_ready go IDLE. Response is never dropped.
//  Latency: rsp_valid rises exactly LAT(op) cycles after the accept edge.
//  Throughput: min LAT+2 cycles per op. New requests are not accepted in DONE.
//  Reserved 11x: issued unchanged to ALU (ALU passes operand1), LAT=FAST_CYCLES.
//  Arithmetic and width: sequencer never alters data; lane wrap/truncation is the ALU's.
//  req_* ignored when req_ready=0; the requester must hold them until accepted.
//  Reset, incl. mid-EXEC/DONE: next cycle state=IDLE, cnt=0, req_ready=1, rsp_valid=0, busy=0.
//   All data outputs (rsp_data, rsp_dz, alu_op1, alu_op2) reset to 0.
//   alu_sel resets to 3'b100 (PASS1). In-flight op discarded, no response.
//  rsp_ready while rsp_valid=0: ignored.
// STRUCTURE
//  aluv_pkg:
//   - opcode enum aluv_op_e
//   - state enum seq_state_e
//   - LANES/DATA_WIDTH defaults
//   - function op_latency(op) returning cycles from the *_CYCLES params
//  Sub-module aluv_latency_lut: op -> cnt load value, combinational.
//  Counter width $clog2(max(*_CYCLES)+1).
// TESTING
//  1 ADD a={1,2,3,4,5,6} b={6,5,4,3,2,1} -> rsp_valid 1 cycle after accept, every lane 7, rsp_dz=0.
//  2 MUL a lanes=16, b lanes=17 -> rsp_valid after 2 cycles, lanes 8'h10 (272 mod 256).
//    alu_op1/op2 stable throughout.
//  3 DIV a lanes=100, b={0,5,0,10,20,50} -> after 4 cycles.
//    rsp_dz=6'b000101, lanes 1/3/4/5 = 20,10,5,2.
//  4 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data hold, req_ready=0.
//    Release -> IDLE next cycle.
//  5 reset asserted 2 cycles into DIV -> next cycle IDLE, rsp_valid=0, alu_sel=3'b100.
//    No response appears afterwards.
//  6 req_op=3'b111, a=0xAA.. -> passes through with FAST_CYCLES latency, rsp_data=a.

Source files
------------

// File: rtl/aluv_pkg.sv
// Shared opcode/state types and per-op latency lookup for the vector ALU issue sequencer.
package aluv_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned LANES_DEF      = 6;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_MUL   = 3'b010,
    OP_DIV   = 3'b011,
    OP_PASS1 = 3'b100,
    OP_PASS2 = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } aluv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Reserved opcodes share the fast budget with ADD/SUB/PASS.
  function automatic int unsigned op_latency(input aluv_op_e op,
                                             input int unsigned fast_c,
                                             input int unsigned mul_c,
                                             input int unsigned div_c);
    case (op)
      OP_MUL:  return mul_c;
      OP_DIV:  return div_c;
      default: return fast_c;
    endcase
  endfunction

endpackage

// File: rtl/aluv_latency_lut.sv
// Maps an opcode to the EXEC down-counter load value (latency minus one).
module aluv_latency_lut
  import aluv_pkg::*;
#(
  parameter int unsigned SELECTOR_SIZE = 3,
  parameter int unsigned FAST_CYCLES   = 1,
  parameter int unsigned MUL_CYCLES    = 2,
  parameter int unsigned DIV_CYCLES    = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic [SELECTOR_SIZE-1:0] op,
  output logic [CNT_W-1:0]         cnt_load
);

  always_comb begin
    cnt_load = CNT_W'(op_latency(aluv_op_e'(op), FAST_CYCLES, MUL_CYCLES, DIV_CYCLES) - 1);
  end

endmodule

// File: rtl/aluv_op_sequencer.sv
// Issue controller for the 6-lane vector ALU: accepts one op, holds the ALU inputs for the
// op's latency, captures the result and returns it over a valid/ready response port.
module aluv_op_sequencer
  import aluv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned LANES         = LANES_DEF,
  parameter int unsigned SELECTOR_SIZE = 3,
  parameter int unsigned FAST_CYCLES   = 1,
  parameter int unsigned MUL_CYCLES    = 2,
  parameter int unsigned DIV_CYCLES    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [SELECTOR_SIZE-1:0]      req_op,
  input  logic [LANES*DATA_WIDTH-1:0]   req_a,
  input  logic [LANES*DATA_WIDTH-1:0]   req_b,
  output logic [SELECTOR_SIZE-1:0]      alu_sel,
  output logic [LANES*DATA_WIDTH-1:0]   alu_op1,
  output logic [LANES*DATA_WIDTH-1:0]   alu_op2,
  input  logic [LANES*DATA_WIDTH-1:0]   alu_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [LANES*DATA_WIDTH-1:0]   rsp_data,
  output logic [LANES-1:0]              rsp_dz,
  output logic                          busy
);

  localparam int unsigned MAX_FM  = (FAST_CYCLES > MUL_CYCLES) ? FAST_CYCLES : MUL_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_FM > DIV_CYCLES) ? MAX_FM : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  seq_state_e                    state;
  logic [CNT_W-1:0]              cnt;
  logic [CNT_W-1:0]              cnt_load;
  logic [SELECTOR_SIZE-1:0]      op_q;
  logic [LANES*DATA_WIDTH-1:0]   a_q;
  logic [LANES*DATA_WIDTH-1:0]   b_q;
  logic [LANES-1:0]              dz_next;

  aluv_latency_lut #(
    .SELECTOR_SIZE (SELECTOR_SIZE),
    .FAST_CYCLES   (FAST_CYCLES),
    .MUL_CYCLES    (MUL_CYCLES),
    .DIV_CYCLES    (DIV_CYCLES),
    .CNT_W         (CNT_W)
  ) u_lut (
    .op       (req_op),
    .cnt_load (cnt_load)
  );

  // ALU inputs come only from the latched request, so they cannot move during EXEC.
  assign alu_sel = op_q;
  assign alu_op1 = a_q;
  assign alu_op2 = b_q;

  always_comb begin
    dz_next = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      dz_next[i] = (aluv_op_e'(op_q) == OP_DIV) && (b_q[i*DATA_WIDTH +: DATA_WIDTH] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= SELECTOR_SIZE'(OP_PASS1);
      a_q       <= '0;
      b_q       <= '0;
      rsp_data  <= '0;
      rsp_dz    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            a_q       <= req_a;
            b_q       <= req_b;
            cnt       <= cnt_load;
            state     <= ST_EXEC;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data  <= alu_out;
            rsp_dz    <= dz_next;
            rsp_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aluv_op_sequencer.sv
// Self-checking bench for aluv_op_sequencer: a behavioural ALU stands in for the parent's ALU,
// and expected results/latencies are computed directly from each request.
module tb_aluv_op_sequencer;

  localparam int DW = 8;
  localparam int LN = 6;
  localparam int W  = DW * LN;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [2:0]    alu_sel;
  logic [W-1:0]  alu_op1;
  logic [W-1:0]  alu_op2;
  logic [W-1:0]  alu_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [LN-1:0] rsp_dz;
  logic          busy;

  int checks = 0;
  int errors = 0;

  aluv_op_sequencer #(
    .DATA_WIDTH    (DW),
    .LANES         (LN),
    .SELECTOR_SIZE (3),
    .FAST_CYCLES   (1),
    .MUL_CYCLES    (2),
    .DIV_CYCLES    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_sel   (alu_sel),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_dz    (rsp_dz),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Lane-wise ALU behaviour; divide by zero yields all-ones in this ALU model.
  function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    int unsigned x, y, z;
    r = '0;
    for (int i = 0; i < LN; i++) begin
      x = int'(a[i*DW +: DW]);
      y = int'(b[i*DW +: DW]);
      case (op)
        3'd0:    z = x + y;
        3'd1:    z = x - y;
        3'd2:    z = x * y;
        3'd3:    z = (y == 0) ? 255 : x / y;
        3'd5:    z = y;
        default: z = x;
      endcase
      r[i*DW +: DW] = z[7:0];
    end
    return r;
  endfunction

  function automatic logic [LN-1:0] dz_ref(input logic [2:0] op, input logic [W-1:0] b);
    logic [LN-1:0] d;
    d = '0;
    for (int i = 0; i < LN; i++) d[i] = (op == 3'd3) && (b[i*DW +: DW] == 8'd0);
    return d;
  endfunction

  function automatic int lat_ref(input logic [2:0] op);
    return (op == 3'd2) ? 2 : (op == 3'd3) ? 4 : 1;
  endfunction

  function automatic logic [W-1:0] mk(input int l0, input int l1, input int l2,
                                      input int l3, input int l4, input int l5);
    return {8'(l5), 8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  function automatic logic [W-1:0] rnd_vec();
    return W'({$urandom, $urandom});
  endfunction

  always_comb alu_out = alu_ref(alu_sel, alu_op1, alu_op2);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble_req(input bit valid);
    req_valid = valid;
    req_op    = 3'($urandom);
    req_a     = rnd_vec();
    req_b     = rnd_vec();
  endtask

  // One full transaction; hold = cycles of rsp_ready low in DONE, early = rsp_ready high
  // from accept onwards, poke = wave junk requests at the DUT while it is busy.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit early, input bit poke);
    logic [W-1:0]  exp_d;
    logic [LN-1:0] exp_dz;
    int            n;
    exp_d  = alu_ref(op, a, b);
    exp_dz = dz_ref(op, b);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_req", 64'(req_ready), 64'(1));
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    rsp_ready = early;
    @(posedge clk); #1;
    scramble_req(poke && ($urandom_range(0, 1) == 1));
    n = 0;
    while (!rsp_valid && n < 20) begin
      chk("exec_sel", 64'(alu_sel), 64'(op));
      chk("exec_op1", 64'(alu_op1), 64'(a));
      chk("exec_op2", 64'(alu_op2), 64'(b));
      chk("exec_req_ready", 64'(req_ready), 64'(0));
      chk("exec_busy", 64'(busy), 64'(1));
      @(posedge clk); #1;
      n++;
      scramble_req(poke && ($urandom_range(0, 1) == 1));
    end
    req_valid = 1'b0;
    chk("latency", 64'(n), 64'(lat_ref(op)));
    if (rsp_valid) begin
      chk("rsp_data", 64'(rsp_data), 64'(exp_d));
      chk("rsp_dz", 64'(rsp_dz), 64'(exp_dz));
      chk("done_req_ready", 64'(req_ready), 64'(0));
      chk("done_busy", 64'(busy), 64'(1));
      if (!early) begin
        for (int k = 0; k < hold; k++) begin
          scramble_req(poke);
          @(posedge clk); #1;
          chk("hold_valid", 64'(rsp_valid), 64'(1));
          chk("hold_data", 64'(rsp_data), 64'(exp_d));
          chk("hold_dz", 64'(rsp_dz), 64'(exp_dz));
          chk("hold_req_ready", 64'(req_ready), 64'(0));
          chk("hold_sel", 64'(alu_sel), 64'(op));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("release_valid", 64'(rsp_valid), 64'(0));
      chk("release_req_ready", 64'(req_ready), 64'(1));
      chk("release_busy", 64'(busy), 64'(0));
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic reset_mid_div();
    req_op    = 3'd3;
    req_a     = mk(100, 100, 100, 100, 100, 100);
    req_b     = mk(0, 5, 0, 10, 20, 50);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_alu_sel", 64'(alu_sel), 64'(3'b100));
    chk("rst_alu_op1", 64'(alu_op1), 64'(0));
    chk("rst_alu_op2", 64'(alu_op2), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_rsp_dz", 64'(rsp_dz), 64'(0));
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", 64'(rsp_valid), 64'(0));
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    reset     = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_req_ready", 64'(req_ready), 64'(1));
    chk("init_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("init_busy", 64'(busy), 64'(0));
    chk("init_alu_sel", 64'(alu_sel), 64'(3'b100));
    chk("init_rsp_data", 64'(rsp_data), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, mk(1, 2, 3, 4, 5, 6), mk(6, 5, 4, 3, 2, 1), 0, 1'b0, 1'b0);
    run_op(3'd2, mk(16, 16, 16, 16, 16, 16), mk(17, 17, 17, 17, 17, 17), 1, 1'b0, 1'b0);
    run_op(3'd3, mk(100, 100, 100, 100, 100, 100), mk(0, 5, 0, 10, 20, 50), 0, 1'b0, 1'b0);
    run_op(3'd1, rnd_vec(), rnd_vec(), 5, 1'b0, 1'b1);
    reset_mid_div();
    run_op(3'd7, {LN{8'hAA}}, rnd_vec(), 0, 1'b0, 1'b0);
    run_op(3'd6, rnd_vec(), rnd_vec(), 0, 1'b1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      rop = 3'($urandom);
      ra  = rnd_vec();
      for (int i = 0; i < LN; i++)
        rb[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      run_op(rop, ra, rb, $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
